multi_debouncer: RTL and testbench
==================================

// Module: multi_debouncer
//
// PURPOSE
// Parametrised N-channel debouncer for buttons/switches.
// Each channel has:
//   - a SYNC_STAGES-flop synchroniser,
//   - a 4-state settle FSM,
//   - one-cycle rise/fall event pulses,
//   - long-press (hold) detection.
// Sits between raw board inputs and control FSMs, which consume pulses, not levels.
//
// PARAMETERS
// CHANNELS      4     number of independent input channels (>=1)
// BOUNCE_TICKS  10    clk cycles an input must settle before re-evaluation (>=1)
// HOLD_TICKS    1000  clk cycles debounced high before held asserts; 0 = hold disabled
// SYNC_STAGES   2     synchroniser depth per channel (>=2)
//
// PORTS
// clk            in   1         system clock, all logic on posedge
// rst            in   1         asynchronous, active-high reset
// bouncy_in      in   CHANNELS  raw asynchronous inputs
// debounced_out  out  CHANNELS  debounced level per channel
// rise_pulse     out  CHANNELS  1-cycle pulse on debounced 0->1
// fall_pulse     out  CHANNELS  1-cycle pulse on debounced 1->0
// held           out  CHANNELS  level: debounced high for >= HOLD_TICKS cycles
// held_pulse     out  CHANNELS  1-cycle pulse when held first asserts
//
// BEHAVIOUR
// - Reset (async, immediate): all sync flops 0; state S_0; counters 0.
//   All outputs 0 while rst=1; no pulses are generated on reset release.
// - Channels are fully independent; the per-channel description below applies to each.
// - sync_in is the output of the last synchroniser stage.
// - FSM, bounce counter width $clog2(BOUNCE_TICKS+1):
//   - S_0: sync_in=1 -> S_MAYBE_1, cnt<=0.
//   - S_1: sync_in=0 -> S_MAYBE_0, cnt<=0.
//   - S_MAYBE_x: cnt increments each cycle. Input glitches do NOT restart cnt.
//     When cnt==BOUNCE_TICKS, sample sync_in:
//     - S_MAYBE_1: sync_in=1 -> S_1 (rise_pulse); else -> S_0 (no pulse).
//     - S_MAYBE_0: sync_in=0 -> S_0 (fall_pulse); else -> S_1 (no pulse).
//   - Illegal state -> S_0.
// - debounced_out = 1 in S_1 and S_MAYBE_0; 0 in S_0 and S_MAYBE_1. Decoded from state flops only.
// - rise_pulse/fall_pulse are registered and high for exactly the first cycle in which debounced_out
//   shows the new value.
// - Latency: input stable from before edge 1 -> debounced_out changes after edge SYNC_STAGES+BOUNCE_TICKS+2
//   (14 with defaults). Pulses appear in the same cycle.
// - Hold counter, width $clog2(HOLD_TICKS+1):
//   - Cleared while debounced_out=0.
//   - Increments while debounced_out=1, saturating at HOLD_TICKS.
//   - held=1 when count==HOLD_TICKS.
//   - held_pulse is high only in the first cycle of held=1.
//   - A MAYBE_0 excursion that returns to S_1 does NOT clear the count.
// - held and held_pulse drop/stay 0 as soon as debounced_out=0.
// - HOLD_TICKS=0: held and held_pulse tied 0, hold counter removed.
// - rise_pulse and held_pulse never coincide when HOLD_TICKS>=1.
// - Reset mid-settle or mid-hold aborts immediately with no pulse; the channel restarts from S_0.
//
// TESTING
// 1. Reset held 5 cycles with bouncy_in=4'hF -> all outputs 0 during reset, no pulse on release.
// 2. Ch0 steps 0->1 and stays (defaults) -> debounced_out[0] rises 14 cycles later with a 1-cycle
//    rise_pulse[0]; other channels stay 0.
// 3. Ch1 toggles every 3 cycles for 30 cycles, then stays 0 -> rise_pulse[1]/fall_pulse[1] are never
//    simultaneous; final debounced_out[1]=0; every rise is matched by a fall.
// 4. Ch2 single 1-cycle glitch to 1 -> enters MAYBE_1, returns to S_0 at cnt==10; no pulses.
// 5. Ch3 held high 1100 cycles after debounce -> held[3] at 1000 cycles after debounced_out rises,
//    with one held_pulse; on release, fall_pulse[3] and held[3] drop.
// 6. All 4 channels step simultaneously; rst pulsed during ch0's MAYBE_1 -> ch0 no rise_pulse,
//    others restart from S_0.

Source files
------------

// File: rtl/multi_debouncer.sv
// ---------------------------------------------------------------------------
// multi_debouncer
//
// N-channel debouncer for buttons and switches. Each channel has its own
// synchroniser, settle FSM, rise/fall event pulses and long-press detection.
// Downstream control logic should consume the one-cycle pulses, not the levels.
//
// Parameters
//   CHANNELS      number of independent channels (>= 1)
//   BOUNCE_TICKS  cycles a channel waits in a MAYBE state before resampling (>= 1)
//   HOLD_TICKS    cycles of debounced-high before held asserts; 0 disables hold
//   SYNC_STAGES   synchroniser depth per channel (>= 2)
//
// Ports
//   clk            in   system clock; all logic runs on the rising edge
//   rst            in   asynchronous, active-high reset
//   bouncy_in      in   raw asynchronous inputs, one bit per channel
//   debounced_out  out  debounced level per channel
//   rise_pulse     out  one-cycle pulse on a debounced 0->1 change
//   fall_pulse     out  one-cycle pulse on a debounced 1->0 change
//   held           out  level: debounced high for at least HOLD_TICKS cycles
//   held_pulse     out  one-cycle pulse in the first cycle held is high
// ---------------------------------------------------------------------------
module multi_debouncer #(
    parameter int CHANNELS     = 4,
    parameter int BOUNCE_TICKS = 10,
    parameter int HOLD_TICKS   = 1000,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] bouncy_in,
    output logic [CHANNELS-1:0] debounced_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] held,
    output logic [CHANNELS-1:0] held_pulse
);

    localparam int                CNT_W   = (BOUNCE_TICKS >= 1) ? $clog2(BOUNCE_TICKS + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(BOUNCE_TICKS);

    // Bit 1 of the encoding is the debounced level, so the level output is
    // taken straight from a state flop with no decode logic.
    typedef enum logic [1:0] {
        S_0       = 2'b00,
        S_MAYBE_1 = 2'b01,
        S_MAYBE_0 = 2'b10,
        S_1       = 2'b11
    } state_e;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync_in_s;
        state_e                 state_q;
        state_e                 state_d;
        logic [CNT_W-1:0]       cnt_q;
        logic [CNT_W-1:0]       cnt_d;
        logic                   deb_q_s;
        logic                   deb_d_s;
        logic                   rise_q;
        logic                   fall_q;

        // Synchroniser shift register for the raw asynchronous input.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], bouncy_in[ch]};
            end
        end

        assign sync_in_s = sync_q[SYNC_STAGES-1];

        // Settle FSM state and bounce counter registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= S_0;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Settle FSM next state. The counter runs unconditionally in the MAYBE
        // states so a chattering input cannot postpone the decision forever;
        // only the sample taken when the count expires matters.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                S_0: begin
                    cnt_d = '0;
                    if (sync_in_s) begin
                        state_d = S_MAYBE_1;
                    end else begin
                        state_d = S_0;
                    end
                end
                S_1: begin
                    cnt_d = '0;
                    if (!sync_in_s) begin
                        state_d = S_MAYBE_0;
                    end else begin
                        state_d = S_1;
                    end
                end
                S_MAYBE_1: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_d   = '0;
                        state_d = sync_in_s ? S_1 : S_0;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = S_MAYBE_1;
                    end
                end
                S_MAYBE_0: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_d   = '0;
                        state_d = sync_in_s ? S_1 : S_0;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = S_MAYBE_0;
                    end
                end
                default: begin
                    state_d = S_0;
                    cnt_d   = '0;
                end
            endcase
        end

        assign deb_q_s = (state_q == S_1) || (state_q == S_MAYBE_0);
        assign deb_d_s = (state_d == S_1) || (state_d == S_MAYBE_0);

        // Edge pulses registered alongside the state, so each is high exactly
        // in the first cycle the debounced level shows its new value.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= deb_d_s & ~deb_q_s;
                fall_q <= ~deb_d_s & deb_q_s;
            end
        end

        assign debounced_out[ch] = deb_q_s;
        assign rise_pulse[ch]    = rise_q;
        assign fall_pulse[ch]    = fall_q;

        if (HOLD_TICKS > 0) begin : g_hold
            localparam int                HOLD_W   = $clog2(HOLD_TICKS + 1);
            localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);

            logic [HOLD_W-1:0] hold_q;
            logic [HOLD_W-1:0] hold_d;
            logic              held_q;
            logic              held_d;
            logic              held_pulse_q;

            // Hold counter next value. It keys off the current debounced level,
            // so a MAYBE_0 excursion (still debounced high) keeps counting.
            always_comb begin
                hold_d = '0;
                if (deb_q_s) begin
                    if (hold_q == HOLD_MAX) begin
                        hold_d = hold_q;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end else begin
                    hold_d = '0;
                end
                // Gating with the next debounced level drops held in the same
                // cycle the debounced output falls.
                held_d = deb_d_s && (hold_d == HOLD_MAX);
            end

            // Hold counter, held level and held pulse registers.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hold_q       <= '0;
                    held_q       <= 1'b0;
                    held_pulse_q <= 1'b0;
                end else begin
                    hold_q       <= hold_d;
                    held_q       <= held_d;
                    held_pulse_q <= held_d & ~held_q;
                end
            end

            assign held[ch]       = held_q;
            assign held_pulse[ch] = held_pulse_q;
        end else begin : g_no_hold
            assign held[ch]       = 1'b0;
            assign held_pulse[ch] = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_debouncer.sv
// ---------------------------------------------------------------------------
// tb_multi_debouncer
//
// Directed bench for multi_debouncer with default parameters. Stimulus code
// pushes hand-computed expectations (levels and pulses, tagged with the cycle
// they are due) into a queue; an independent monitor on the falling edge pops
// the entries due in the current cycle and compares them to the outputs.
// Any pulse the DUT raises that was not expected is flagged as well.
// ---------------------------------------------------------------------------
module tb_multi_debouncer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] bouncy_in = 4'hF;
    logic [3:0] debounced_out;
    logic [3:0] rise_pulse;
    logic [3:0] fall_pulse;
    logic [3:0] held;
    logic [3:0] held_pulse;

    multi_debouncer #(
        .CHANNELS    (4),
        .BOUNCE_TICKS(10),
        .HOLD_TICKS  (1000),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bouncy_in    (bouncy_in),
        .debounced_out(debounced_out),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .held         (held),
        .held_pulse   (held_pulse)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 debounced level, 1 held level, 2 rise, 3 fall, 4 held_pulse
    typedef struct {
        int         at;
        int         kind;
        logic [3:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic push(input int c, input int k, input logic [3:0] v);
        exp_t e;
        e.at   = c;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    // Returns 1 time unit after rising edge number c.
    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: checks everything due this cycle, plus any unexpected pulse.
    always @(negedge clk) begin : mon
        logic [3:0] e_r;
        logic [3:0] e_f;
        logic [3:0] e_h;
        e_r = 4'h0;
        e_f = 4'h0;
        e_h = 4'h0;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].at == cyc) begin
                case (exp_q[i].kind)
                    0: begin
                        n_cmp++;
                        if (debounced_out !== exp_q[i].val) begin
                            n_fail++;
                            $display("FAIL deb_level cyc=%0d got=%b exp=%b", cyc, debounced_out, exp_q[i].val);
                        end
                    end
                    1: begin
                        n_cmp++;
                        if (held !== exp_q[i].val) begin
                            n_fail++;
                            $display("FAIL held_level cyc=%0d got=%b exp=%b", cyc, held, exp_q[i].val);
                        end
                    end
                    2: e_r = e_r | exp_q[i].val;
                    3: e_f = e_f | exp_q[i].val;
                    default: e_h = e_h | exp_q[i].val;
                endcase
                exp_q.delete(i);
            end
        end
        if (({e_r, e_f, e_h} != 12'h000) || ({rise_pulse, fall_pulse, held_pulse} != 12'h000)) begin
            n_cmp++;
            if ({rise_pulse, fall_pulse, held_pulse} !== {e_r, e_f, e_h}) begin
                n_fail++;
                $display("FAIL pulses cyc=%0d got rise=%b fall=%b hp=%b exp rise=%b fall=%b hp=%b",
                         cyc, rise_pulse, fall_pulse, held_pulse, e_r, e_f, e_h);
            end
        end
    end

    initial begin
        // 1: reset with all inputs high, then release; all four rise 14 later
        for (int c = 1; c <= 5; c++) begin
            push(c, 0, 4'h0);
            push(c, 1, 4'h0);
        end
        push(18, 0, 4'h0);
        push(19, 0, 4'hF);
        push(19, 2, 4'hF);
        wait_to(5);
        rst = 1'b0;
        wait_to(25);
        rst       = 1'b1;
        bouncy_in = 4'h0;
        push(25, 0, 4'h0);
        push(26, 0, 4'h0);
        wait_to(27);
        rst = 1'b0;

        // 2: ch0 step up then down
        wait_to(30);
        bouncy_in[0] = 1'b1;
        push(43, 0, 4'b0000);
        push(44, 0, 4'b0001);
        push(44, 2, 4'b0001);
        wait_to(60);
        bouncy_in[0] = 1'b0;
        push(73, 0, 4'b0001);
        push(74, 0, 4'b0000);
        push(74, 3, 4'b0001);

        // 3: ch1 toggles every 3 cycles; every sample lands low, no pulses
        push(93, 0, 4'h0);
        push(100, 0, 4'h0);
        push(120, 0, 4'h0);
        for (int k = 0; k < 10; k++) begin
            wait_to(80 + 3 * k);
            bouncy_in[1] = (k % 2 == 0) ? 1'b1 : 1'b0;
        end

        // 4a: ch2 single-cycle glitch, no pulses
        wait_to(130);
        bouncy_in[2] = 1'b1;
        push(143, 0, 4'h0);
        push(144, 0, 4'h0);
        push(145, 0, 4'h0);
        wait_to(131);
        bouncy_in[2] = 1'b0;
        // 4b: chatter early in MAYBE_1 does not restart the count
        wait_to(150);
        bouncy_in[2] = 1'b1;
        wait_to(151);
        bouncy_in[2] = 1'b0;
        wait_to(155);
        bouncy_in[2] = 1'b1;
        push(163, 0, 4'b0000);
        push(164, 0, 4'b0100);
        push(164, 2, 4'b0100);
        // 4c: low glitch while high returns to S_1 silently
        wait_to(180);
        bouncy_in[2] = 1'b0;
        push(185, 0, 4'b0100);
        push(194, 0, 4'b0100);
        push(195, 0, 4'b0100);
        wait_to(181);
        bouncy_in[2] = 1'b1;
        wait_to(200);
        bouncy_in[2] = 1'b0;
        push(213, 0, 4'b0100);
        push(214, 0, 4'b0000);
        push(214, 3, 4'b0100);

        // 5: ch3 long press with a MAYBE_0 excursion midway
        wait_to(220);
        bouncy_in[3] = 1'b1;
        push(233, 0, 4'b0000);
        push(234, 0, 4'b1000);
        push(234, 2, 4'b1000);
        wait_to(720);
        bouncy_in[3] = 1'b0;
        push(725, 0, 4'b1000);
        push(735, 0, 4'b1000);
        wait_to(721);
        bouncy_in[3] = 1'b1;
        push(1233, 1, 4'b0000);
        push(1234, 1, 4'b1000);
        push(1234, 4, 4'b1000);
        push(1347, 0, 4'b1000);
        push(1347, 1, 4'b1000);
        push(1348, 0, 4'b0000);
        push(1348, 1, 4'b0000);
        push(1348, 3, 4'b1000);
        wait_to(1334);
        bouncy_in[3] = 1'b0;

        // 6: all channels step; reset mid-settle, ch0 released low
        wait_to(1360);
        bouncy_in = 4'hF;
        push(1363, 0, 4'h0);
        wait_to(1366);
        rst          = 1'b1;
        bouncy_in[0] = 1'b0;
        push(1366, 0, 4'h0);
        push(1367, 0, 4'h0);
        push(1374, 0, 4'h0);
        push(1381, 0, 4'h0);
        push(1382, 0, 4'b1110);
        push(1382, 2, 4'b1110);
        push(1390, 1, 4'h0);
        wait_to(1368);
        rst = 1'b0;

        wait_to(1400);
        @(negedge clk);
        #1;
        foreach (exp_q[i]) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unchecked_expectation at=%0d kind=%0d got=none exp=%b", exp_q[i].at, exp_q[i].kind, exp_q[i].val);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
